// File: rtl/fp_add_arb_pkg.sv
// Shared types and constants for the fp_add_arbiter slice.
package fp_add_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int unsigned N_REQ_DEFAULT = 4;

  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

endpackage

// File: rtl/floatingPointAdder.sv
// Combinational IEEE-754 single-precision adder, round-to-nearest-even,
// subnormals supported, any NaN input produces the canonical quiet NaN.
module floatingPointAdder
  import fp_add_arb_pkg::*;
(
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic [31:0] sum
);

  logic        x_nan, y_nan, x_inf, y_inf;
  logic        big_s, sml_s;
  logic [7:0]  big_e, sml_e;
  logic [23:0] big_m, sml_m;
  logic [7:0]  diff;
  logic [26:0] sml_full, sml_sh;
  logic [27:0] raw;
  logic [26:0] pre, norm;
  logic [9:0]  exp_w, fin_e;
  logic [4:0]  lz, shamt;
  logic [24:0] rnd;
  logic        inc;

  assign x_nan = (&x[30:23]) && (|x[22:0]);
  assign y_nan = (&y[30:23]) && (|y[22:0]);
  assign x_inf = (&x[30:23]) && !(|x[22:0]);
  assign y_inf = (&y[30:23]) && !(|y[22:0]);

  // Align, add/subtract, normalise (clamped to the subnormal range), round.
  always_comb begin
    if (x[30:0] >= y[30:0]) begin
      big_s = x[31];
      big_e = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
      big_m = {|x[30:23], x[22:0]};
      sml_s = y[31];
      sml_e = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
      sml_m = {|y[30:23], y[22:0]};
    end else begin
      big_s = y[31];
      big_e = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
      big_m = {|y[30:23], y[22:0]};
      sml_s = x[31];
      sml_e = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
      sml_m = {|x[30:23], x[22:0]};
    end

    // Three extra bits below the LSB: guard, round, sticky.
    diff     = big_e - sml_e;
    sml_full = {sml_m, 3'b000};
    if (diff >= 8'd27) begin
      sml_sh = {26'd0, |sml_m};
    end else begin
      sml_sh    = sml_full >> diff;
      sml_sh[0] = sml_sh[0] | (|(sml_full & ((27'd1 << diff) - 27'd1)));
    end

    if (big_s == sml_s) raw = {1'b0, big_m, 3'b000} + {1'b0, sml_sh};
    else                raw = {1'b0, big_m, 3'b000} - {1'b0, sml_sh};

    exp_w = {2'b00, big_e};
    if (raw[27]) begin
      pre   = {raw[27:2], raw[1] | raw[0]};
      exp_w = exp_w + 10'd1;
    end else begin
      pre = raw[26:0];
    end

    lz = 5'd27;
    for (int unsigned i = 0; i < 27; i++) begin
      if (pre[i]) lz = 5'(26 - i);
    end
    // Never shift the exponent below 1; what remains is a subnormal.
    if ({5'd0, lz} > exp_w - 10'd1) shamt = 5'(exp_w - 10'd1);
    else                            shamt = lz;
    norm  = pre << shamt;
    fin_e = exp_w - {5'd0, shamt};

    inc = norm[2] & (norm[1] | norm[0] | norm[3]);
    rnd = {1'b0, norm[26:3]} + {24'd0, inc};
    // Carry out bumps the exponent; no hidden bit means subnormal/zero.
    if (rnd[24])       fin_e = fin_e + 10'd1;
    else if (!rnd[23]) fin_e = '0;

    if (x_nan || y_nan || (x_inf && y_inf && (x[31] != y[31]))) sum = FP_QNAN;
    else if (x_inf)                                           sum = x;
    else if (y_inf)                                           sum = y;
    else if (raw == 28'd0)                                    sum = {big_s & sml_s, 31'd0};
    else if (fin_e >= 10'd255)                                sum = {big_s, 8'hFF, 23'd0};
    else                                                      sum = {big_s, fin_e[7:0], rnd[22:0]};
  end

endmodule

// File: rtl/fp_add_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after rr_ptr.
module rr_arbiter
  import fp_add_arb_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEFAULT,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  logic [ID_W-1:0] cand;

  // Scan from farthest to nearest so the candidate closest to rr_ptr wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    cand  = '0;
    any   = |req;
    for (int unsigned k = N_REQ; k > 0; k--) begin
      cand = ID_W'((32'(rr_ptr) + k - 1) % N_REQ);
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/fp_add_arbiter.sv
// Round-robin sequencer sharing one floatingPointAdder among N_REQ clients.
// Optional FP_ADD_ARB_SUB_EN adds per-requester req_sub to compute x-y.
module fp_add_arbiter
  import fp_add_arb_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEFAULT,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [32*N_REQ-1:0] req_x,
  input  logic [32*N_REQ-1:0] req_y,
`ifdef FP_ADD_ARB_SUB_EN
  input  logic [N_REQ-1:0]    req_sub,
`endif
  output logic [N_REQ-1:0]    req_ready,
  output logic                rsp_valid,
  output logic [31:0]         rsp_data,
  output logic [ID_W-1:0]     rsp_id,
  input  logic                rsp_ready,
  output logic                busy
);

  state_t          state, state_next;
  logic [ID_W-1:0] rr_ptr, id_q, gnt_idx;
  logic [N_REQ-1:0] gnt;
  logic            gnt_any;
  logic [31:0]     x_q, y_q, sel_x, sel_y, sum;
  logic            sel_sub;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req    (req_valid),
    .rr_ptr (rr_ptr),
    .grant  (gnt),
    .idx    (gnt_idx),
    .any    (gnt_any)
  );

  floatingPointAdder u_add (
    .x   (x_q),
    .y   (y_q),
    .sum (sum)
  );

  // Operand pair of the requester currently winning arbitration.
  always_comb begin
    sel_x   = '0;
    sel_y   = '0;
    sel_sub = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (ID_W'(i) == gnt_idx) begin
        sel_x = req_x[i*32 +: 32];
        sel_y = req_y[i*32 +: 32];
`ifdef FP_ADD_ARB_SUB_EN
        sel_sub = req_sub[i];
`endif
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (gnt_any) state_next = CALC;
      CALC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Grant is only visible while idle.
  always_comb begin
    req_ready = (state == IDLE) ? gnt : '0;
  end

  // Registered busy flag tracks the state being entered.
  always_ff @(posedge clk) begin
    if (rst) busy <= 1'b0;
    else     busy <= (state_next != IDLE);
  end

  // Operand latch, round-robin pointer and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q       <= '0;
      y_q       <= '0;
      id_q      <= '0;
      rr_ptr    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            x_q    <= sel_x;
            // Flipping the sign of y turns the add into x-y.
            y_q    <= {sel_y[31] ^ sel_sub, sel_y[30:0]};
            id_q   <= gnt_idx;
            rr_ptr <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          end
        end
        CALC: begin
          rsp_data  <= sum;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: rsp_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: doc/fp_add_arbiter.md
# fp_add_arbiter

Round-robin arbiter and sequencer that shares one combinational single-precision adder (`floatingPointAdder`) among `N_REQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester, latches its operands, registers the adder result, and returns the result tagged with the requester index. It sits between the FP-issuing clients and the adder datapath. It is the only driver of the adder's inputs.

## Interface
- `N_REQ`, 4, number of requesters (2..8).
- `ID_W`, `$clog2(N_REQ)`, width of the requester tag.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  N_REQ  per-requester operand-pair valid.
- `req_x`  in  32*N_REQ  operand x; requester i uses bits [32i+31:32i].
- `req_y`  in  32*N_REQ  operand y, same packing as `req_x`.
- `req_ready`  out  N_REQ  one-hot grant/accept; zero or one bit high per cycle.
- `rsp_valid`  out  1  result valid.
- `rsp_data`  out  32  IEEE-754 single result of x+y.
- `rsp_id`  out  ID_W  index of the requester that owns `rsp_data`.
- `rsp_ready`  in  1  consumer accepts the result.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, CALC, RESP.
- **IDLE.** If any `req_valid` bit is set, pick the first set bit at or after `rr_ptr`, wrapping modulo N_REQ.
  - Drive `req_ready[g]=1` combinationally in the same cycle.
  - On the clock edge, latch `x_q`, `y_q` and `id_q=g`, set `rr_ptr=(g+1) mod N_REQ`, and go to CALC.
- **CALC.** The adder evaluates `x_q`, `y_q`. On the edge, `rsp_data<=sum`, `rsp_id<=id_q`, `rsp_valid<=1`, and go to RESP.
- **RESP.** Hold `rsp_valid`, `rsp_data` and `rsp_id` stable until `rsp_valid&&rsp_ready`. On that edge, `rsp_valid<=0` and go to IDLE.
- `req_ready` is 0 in CALC and RESP. There is no new grant until IDLE.
- Requesters hold `req_valid` and operands until they see `req_ready`. The arbiter only samples operands in the grant cycle. Dropping `req_valid` before grant is legal and simply removes that requester from arbitration.
- Simultaneous requests: exactly one grant per IDLE cycle. The others wait, and no request is lost.
- `rr_ptr` wraps from N_REQ-1 to 0. With a single persistent requester, it is granted on every IDLE pass.
- Results are numerically identical to the adder. Special cases (NaN 0x7FC00000, infinity, zero) pass through untouched.
- Reset values: `rr_ptr=0`, state IDLE, `rsp_valid=0`, `rsp_data=0`, `rsp_id=0`, `x_q=y_q=0`, `req_ready=0`, `busy=0`.
- Reset mid-operation (CALC or RESP) discards the in-flight transaction. No response is produced for it.

## Timing
- Grant cycle T (IDLE, `req_ready` high) → `rsp_valid` high at T+2.
- With `rsp_ready` tied high, one transaction completes every 3 cycles: grant T, CALC T+1, RESP T+2, next grant T+3.
- Backpressure: each cycle `rsp_ready` is low extends RESP by one cycle. Outputs are stable throughout.
- `req_ready` is combinational from `req_valid` and `rr_ptr` in IDLE only. All other outputs are registered.
- `busy` is registered, derived from the state.

## Configuration
- **`FP_ADD_ARB_SUB_EN` defined:** adds input `req_sub` [N_REQ]. In the grant cycle, `y_q <= {req_y_g[31]^req_sub[g], req_y_g[30:0]}`, so a set bit computes x−y.
- **`FP_ADD_ARB_SUB_EN` undefined:** `req_sub` does not exist and every transaction is x+y.

## Structure
- Package `fp_add_arb_pkg`:
  - state enum (IDLE, CALC, RESP);
  - default `N_REQ`;
  - constants `FP_QNAN=32'h7FC00000`, `FP_ONE=32'h3F800000`.
- Natural sub-module: `rr_arbiter` (combinational round-robin picker: `req` vector + `rr_ptr` → one-hot grant + index).
- The top instantiates `rr_arbiter`, the FSM, the operand/result registers and one `floatingPointAdder`.

## Test plan
- **Basic add.** Single request on id 2, x=0x3F800000, y=0x40000000 → `req_ready[2]` at grant cycle T; `rsp_valid` at T+2 with `rsp_data=0x40400000`, `rsp_id=2`.
- **Round-robin fairness.** All 4 `req_valid` held high, `rsp_ready=1` → grants in order 0,1,2,3,0 every 3 cycles; `rr_ptr` wraps.
- **Backpressure.** `rsp_ready` held low 5 cycles after `rsp_valid` rises → `rsp_data`/`rsp_id` stable, `req_ready=0`, `busy=1`; next grant 1 cycle after the accept.
- **Special value passthrough.** x=0x7FC00000, y=0x3F800000 → `rsp_data=0x7FC00000`. Separately, x=0x7F800000, y=0x3F800000 → `rsp_data=0x7F800000`.
- **Reset mid-CALC.** Assert `rst` for 1 cycle during CALC → no `rsp_valid` for that transaction; state IDLE; `rr_ptr=0`; next request on id 3 is granted normally.
- **Subtract (`FP_ADD_ARB_SUB_EN`).** x=0x40400000, y=0x3F800000, `req_sub=1` → `rsp_data=0x40000000`. With the macro undefined, the same operands give 0x40800000.
